tube_display_arbiter: RTL

//  Time-shares the 8-digit seven-segment display among 4 requesters (e.g. CPU MMIO write,
//  PC trace, switch echo, error code). Requesters use req/ack handshakes; the winner is chosen

---
 rtl/tube_display_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/tube_display_arbiter.sv
// tube_display_arbiter
// Round-robin arbiter that time-shares the 8-digit hex tube among four
// requesters. The granted word is latched onto show_data and held there for
// HOLD_CYCLES clocks so it stays readable before the next grant can occur.

module tube_display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 50_000_000,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [31:0] data3,
   output logic [3:0]  ack,
   output logic [31:0] show_data,
   output logic [1:0]  show_src,
   output logic        busy
);

   localparam int unsigned   TW         = $clog2(HOLD_CYCLES) + 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]    r_state;
   logic [TW-1:0] r_timer;
   logic [1:0]    r_last;
   logic [3:0]    r_ack;
   logic [31:0]   r_show_data;
   logic [1:0]    r_show_src;
   logic          r_busy;

   logic          w_found;
   logic [1:0]    w_win;
   logic [1:0]    w_idx;
   logic [31:0]   w_data;

   // Round-robin search: scan last+1, last+2, last+3, last (mod 4); first hit wins
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         w_idx = r_last + k[1:0];
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   // Select the word of the current winner
   always_comb begin
      w_data = data0;
      case (w_win)
         2'd0:    w_data = data0;
         2'd1:    w_data = data1;
         2'd2:    w_data = data2;
         default: w_data = data3;
      endcase
   end

   // Grant/dwell state machine; every output is a register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_last      <= 2'd3;
         r_ack       <= '0;
         r_show_data <= RESET_VALUE;
         r_show_src  <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_ack <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_show_data <= w_data;
                  r_show_src  <= w_win;
                  r_ack       <= 4'b0001 << w_win;
                  r_last      <= w_win;
                  r_timer     <= TIMER_LOAD;
                  r_busy      <= 1'b1;
                  r_state     <= ST_HOLD;
               end
            end
            default: begin
               // timer is loaded with HOLD_CYCLES-1 so HOLD spans exactly HOLD_CYCLES clocks
               if (r_timer != '0) begin
                  r_timer <= r_timer - 1'b1;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign ack       = r_ack;
   assign show_data = r_show_data;
   assign show_src  = r_show_src;
   assign busy      = r_busy;

endmodule
